// File: rtl/ring_osc_pkg.sv
// Shared definitions for the clocked ring-oscillator model: trim width,
// half-period counter width and the trim popcount helper.
package ring_osc_pkg;

  localparam int TRIM_W = 26;
  localparam int HALF_W = 16;

  // Trim is thermometer-like: only the number of set bits matters.
  function automatic logic [4:0] popcount26(input logic [25:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 26; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/ring_osc_phase_gen.sv
// Half-period counter driving the internal hiclock and the two quadrature
// outputs; every toggle of hiclock advances exactly one of the two phases.
module ring_osc_phase_gen
  import ring_osc_pkg::*;
(
  input  logic              clk,
  input  logic              ireset,
  input  logic [HALF_W-1:0] half,
  output logic [1:0]        clockp
);

  logic [HALF_W-1:0] cnt;
  logic              hiclock;
  logic              toggle;

  // ">=" rather than "==" so a shrinking half never lets cnt wrap past it.
  assign toggle = (cnt >= half - HALF_W'(1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of cnt/hiclock, independent of statement order.
  always_ff @(posedge clk) begin
    if (ireset) begin
      cnt     <= '0;
      hiclock <= 1'b0;
      clockp  <= 2'b00;
    end else if (toggle) begin
      cnt     <= '0;
      hiclock <= ~hiclock;
      if (!hiclock) clockp[0] <= ~clockp[0];
      else          clockp[1] <= ~clockp[1];
    end else begin
      cnt <= cnt + HALF_W'(1);
    end
  end

endmodule

// File: rtl/ring_osc_clocked_model.sv
// Clocked functional model of the 13-stage trimmable DCO: selects the trim
// source, converts its bit count to a half-period and drives the phase generator.
module ring_osc_clocked_model
  import ring_osc_pkg::*;
#(
  parameter int BASE_TICKS = 8,
  parameter int STEP_TICKS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              dco,
  input  logic [TRIM_W-1:0] ext_trim,
  input  logic [TRIM_W-1:0] trim,
  output logic [1:0]        clockp
);

  logic [TRIM_W-1:0] itrim;
  logic [4:0]        bcount;
  logic [HALF_W-1:0] half;
  logic              ireset;

  assign itrim  = dco ? ext_trim : trim;
  assign bcount = popcount26(itrim);
  assign half   = HALF_W'(BASE_TICKS) + HALF_W'(STEP_TICKS) * HALF_W'(bcount);

  // Disabling the oscillator is indistinguishable from resetting it.
  assign ireset = reset | ~enable;

  ring_osc_phase_gen u_phase_gen (
    .clk   (clk),
    .ireset(ireset),
    .half  (half),
    .clockp(clockp)
  );

endmodule

// File: tb/tb_ring_osc_clocked_model.sv
// Self-checking bench for ring_osc_clocked_model: table of trim settings,
// directed corner sequences and a randomized run against an event-count model.
module tb_ring_osc_clocked_model;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        dco = 1'b0;
  logic [25:0] ext_trim = '0;
  logic [25:0] trim = '0;
  logic [1:0]  clockp;

  int n_cmp = 0;
  int n_bad = 0;

  ring_osc_clocked_model #(.BASE_TICKS(8), .STEP_TICKS(1)) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .dco     (dco),
    .ext_trim(ext_trim),
    .trim    (trim),
    .clockp  (clockp)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [25:0] trim;
    logic [25:0] ext;
    bit          dco;
    int          period;
    int          half;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) begin
      step();
      check("reset_hold", {30'd0, clockp}, 32'd0);
    end
    reset = 1'b0;
  endtask

  // Edge numbers (counted from the call) of phase transitions; -1 if not seen.
  task automatic run_events(input int budget, output int e0r, output int e1r,
                            output int e0f, output int e1f, output int e0r2);
    logic [1:0] prev;
    e0r = -1; e1r = -1; e0f = -1; e1f = -1; e0r2 = -1;
    prev = clockp;
    for (int k = 1; k <= budget; k++) begin
      step();
      if (!prev[0] && clockp[0]) begin
        if (e0r < 0) e0r = k;
        else if (e0r2 < 0) e0r2 = k;
      end
      if (!prev[1] && clockp[1] && e1r < 0) e1r = k;
      if (prev[0] && !clockp[0] && e0f < 0) e0f = k;
      if (prev[1] && !clockp[1] && e1f < 0) e1f = k;
      prev = clockp;
      if (e0r2 >= 0) break;
    end
  endtask

  function automatic logic [25:0] make_trim(input int nbits);
    logic [25:0] t;
    t = '0;
    while ($countones(t) < nbits) t[$urandom_range(0, 25)] = 1'b1;
    return t;
  endfunction

  // Reference: output phase as a function of the number of half-period events.
  function automatic logic [1:0] phase_of(input int n);
    case (n % 4)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  initial begin
    int e0r, e1r, e0f, e1f, e0r2;
    int m_events, m_elapsed, m_half;

    vecs[0] = '{"bits0",   26'h0000000, 26'h0000000, 1'b0,  32,  8};
    vecs[1] = '{"bits1",   26'h0000001, 26'h0000000, 1'b0,  36,  9};
    vecs[2] = '{"bits13",  26'h0001FFF, 26'h0000000, 1'b0,  84, 21};
    vecs[3] = '{"bits26",  26'h3FFFFFF, 26'h0000000, 1'b0, 136, 34};
    vecs[4] = '{"ext_sel", 26'h0000000, 26'h3FFFFFF, 1'b1, 136, 34};
    vecs[5] = '{"int_sel", 26'h0000000, 26'h3FFFFFF, 1'b0,  32,  8};
    vecs[6] = '{"pos_lsb", 26'h0000001, 26'h0000000, 1'b0,  36,  9};
    vecs[7] = '{"pos_msb", 26'h2000000, 26'h0000000, 1'b0,  36,  9};

    // Reset and table sweep: each entry restarts from reset.
    foreach (vecs[i]) begin
      trim = vecs[i].trim; ext_trim = vecs[i].ext; dco = vecs[i].dco;
      do_reset();
      run_events(6 * vecs[i].period, e0r, e1r, e0f, e1f, e0r2);
      check({vecs[i].name, "_p0_rise"}, e0r, vecs[i].half);
      check({vecs[i].name, "_p1_rise"}, e1r, 2 * vecs[i].half);
      check({vecs[i].name, "_p0_fall"}, e0f, 3 * vecs[i].half);
      check({vecs[i].name, "_p1_fall"}, e1f, 4 * vecs[i].half);
      check({vecs[i].name, "_period"}, e0r2 - e0r, vecs[i].period);
    end

    // Mid-period trim drop from half=34 to half=8.
    trim = 26'h3FFFFFF; ext_trim = '0; dco = 1'b0;
    do_reset();
    repeat (20) step();
    check("mid_drop_before", {30'd0, clockp}, 32'd0);
    trim = '0;
    step();
    check("mid_drop_toggle", {30'd0, clockp}, 32'd1);
    run_events(200, e0r, e1r, e0f, e1f, e0r2);
    check("mid_drop_p1_rise", e1r, 8);
    check("mid_drop_p0_rise", e0r, 32);
    check("mid_drop_period", e0r2 - e0r, 32);

    // Enable drop mid-run, then restart.
    do_reset();
    repeat (10) step();
    check("en_running", {30'd0, clockp}, 32'd1);
    enable = 1'b0;
    step();
    check("en_off_next", {30'd0, clockp}, 32'd0);
    repeat (5) step();
    check("en_off_held", {30'd0, clockp}, 32'd0);
    enable = 1'b1;
    run_events(100, e0r, e1r, e0f, e1f, e0r2);
    check("en_restart_p0", e0r, 8);
    check("en_restart_p1", e1r, 16);

    // Reset while both phases are high.
    do_reset();
    repeat (16) step();
    check("rst11_state", {30'd0, clockp}, 32'd3);
    reset = 1'b1;
    step();
    check("rst11_cleared", {30'd0, clockp}, 32'd0);
    reset = 1'b0;
    run_events(100, e0r, e1r, e0f, e1f, e0r2);
    check("rst11_restart_p0", e0r, 8);
    check("rst11_restart_p1", e1r, 16);

    // Randomized run against the event-count model.
    trim = make_trim($urandom_range(0, 26));
    ext_trim = make_trim($urandom_range(0, 26));
    dco = 1'b0;
    do_reset();
    m_events = 0;
    m_elapsed = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 39) == 0) trim = make_trim($urandom_range(0, 26));
      if ($urandom_range(0, 49) == 0) ext_trim = make_trim($urandom_range(0, 26));
      if ($urandom_range(0, 79) == 0) dco = ~dco;
      if ($urandom_range(0, 249) == 0) enable = ~enable;
      else if (!enable && $urandom_range(0, 9) == 0) enable = 1'b1;
      reset = ($urandom_range(0, 399) == 0);
      m_half = 8 + $countones(dco ? ext_trim : trim);
      if (reset || !enable) begin
        m_events = 0;
        m_elapsed = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed >= m_half) begin
          m_events++;
          m_elapsed = 0;
        end
      end
      step();
      check("random", {30'd0, clockp}, {30'd0, phase_of(m_events)});
    end
    reset = 1'b0;
    enable = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
